// File: rtl/md5_lane_scheduler.sv
// md5_lane_scheduler: hands candidate plaintexts to LANES independent MD5
// hashers (lowest free lane first), collects their digests, compares each
// against the captured target and reports the first matching plaintext.
// Supports stop-on-first-match and count-all-matches operation, plus a
// clean drain of in-flight work before DONE.
module md5_lane_scheduler #(
  parameter int LANES         = 4,
  parameter bit STOP_ON_MATCH = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   start_i,
  input  logic [127:0]           target_hash_i,
  input  logic                   cand_valid_i,
  output logic                   cand_ready_o,
  input  logic [127:0]           cand_word_i,
  input  logic [7:0]             cand_len_i,
  input  logic                   cand_last_i,
  output logic [LANES-1:0]       lane_msg_valid_o,
  output logic [128*LANES-1:0]   lane_word_o,
  output logic [8*LANES-1:0]     lane_width_o,
  input  logic [LANES-1:0]       lane_ready_i,
  input  logic [LANES-1:0]       lane_out_valid_i,
  input  logic [128*LANES-1:0]   lane_hash_i,
  output logic                   busy_o,
  output logic                   found_o,
  output logic                   exhausted_o,
  output logic                   len_error_o,
  output logic [127:0]           plaintext_o,
  output logic [7:0]             plain_len_o,
  output logic [3:0]             match_lane_o,
  output logic [CNT_W-1:0]       hashes_done_o,
  output logic [CNT_W-1:0]       match_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [LANES-1:0] LANE_ONE = LANES'(1);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [4:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-4){1'b0}}, b};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Registered state (_q) and next-state (_d)
  state_e                 state_q, state_d;
  logic [LANES-1:0]       inflight_q, inflight_d;
  logic                   busy_q, busy_d;
  logic                   found_q, found_d;
  logic                   exhausted_q, exhausted_d;
  logic                   len_error_q, len_error_d;
  logic                   src_end_q, src_end_d;
  logic [127:0]           target_q, target_d;
  logic [127:0]           plaintext_q, plaintext_d;
  logic [7:0]             plain_len_q, plain_len_d;
  logic [3:0]             match_lane_q, match_lane_d;
  logic [CNT_W-1:0]       hashes_done_q, hashes_done_d;
  logic [CNT_W-1:0]       match_count_q, match_count_d;
  logic [LANES-1:0]       msg_valid_q, msg_valid_d;
  logic [128*LANES-1:0]   lane_word_q, lane_word_d;
  logic [8*LANES-1:0]     lane_width_q, lane_width_d;
  logic [127:0]           shadow_word_q [LANES];
  logic [127:0]           shadow_word_d [LANES];
  logic [7:0]             shadow_len_q  [LANES];
  logic [7:0]             shadow_len_d  [LANES];

  // Decode signals
  logic [LANES-1:0]       free_s;
  logic [LANES-1:0]       pick_oh_s;
  logic [LANES-1:0]       done_vec_s;
  logic [LANES-1:0]       match_vec_s;
  logic [LANES-1:0]       first_oh_s;
  logic [4:0]             done_cnt_s;
  logic [4:0]             match_cnt_s;
  logic                   legal_len_s;
  logic                   hs_s;
  logic                   go_drain_s;

  // Ready depends only on registered state, lane_ready and in-flight flags.
  assign cand_ready_o = (state_q == ST_RUN) && (free_s != '0);
  assign hs_s         = cand_valid_i && cand_ready_o;
  assign legal_len_s  = (cand_len_i != 8'd0) && (cand_len_i[2:0] == 3'd0) &&
                        (cand_len_i <= 8'd128);

  // Lane selection and completion decode (free lanes, matches, popcounts).
  always_comb begin
    free_s      = ~inflight_q & lane_ready_i;
    pick_oh_s   = free_s & (~free_s + LANE_ONE);
    done_vec_s  = lane_out_valid_i & inflight_q;
    match_vec_s = '0;
    done_cnt_s  = 5'd0;
    match_cnt_s = 5'd0;
    for (int i = 0; i < LANES; i++) begin
      if (done_vec_s[i] && (lane_hash_i[i*128 +: 128] == target_q)) begin
        match_vec_s[i] = 1'b1;
      end else begin
        match_vec_s[i] = 1'b0;
      end
      done_cnt_s  = done_cnt_s  + {4'd0, done_vec_s[i]};
      match_cnt_s = match_cnt_s + {4'd0, match_vec_s[i]};
    end
    first_oh_s = match_vec_s & (~match_vec_s + LANE_ONE);
  end

  // Next-state logic for the search FSM, lanes, counters and result capture.
  always_comb begin
    state_d       = state_q;
    inflight_d    = inflight_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    len_error_d   = len_error_q;
    src_end_d     = src_end_q;
    target_d      = target_q;
    plaintext_d   = plaintext_q;
    plain_len_d   = plain_len_q;
    match_lane_d  = match_lane_q;
    hashes_done_d = hashes_done_q;
    match_count_d = match_count_q;
    msg_valid_d   = '0;
    lane_word_d   = lane_word_q;
    lane_width_d  = lane_width_q;
    go_drain_s    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      shadow_word_d[i] = shadow_word_q[i];
      shadow_len_d[i]  = shadow_len_q[i];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d       = ST_RUN;
          inflight_d    = '0;
          found_d       = 1'b0;
          exhausted_d   = 1'b0;
          len_error_d   = 1'b0;
          src_end_d     = 1'b0;
          target_d      = target_hash_i;
          plaintext_d   = 128'd0;
          plain_len_d   = 8'd0;
          match_lane_d  = 4'd0;
          hashes_done_d = {CNT_W{1'b0}};
          match_count_d = {CNT_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN, ST_DRAIN: begin
        // Completions: retire lanes, count digests and matches.
        inflight_d    = inflight_q & ~done_vec_s;
        hashes_done_d = sat_add(hashes_done_q, done_cnt_s);
        match_count_d = sat_add(match_count_q, match_cnt_s);
        if (match_vec_s != '0) begin
          found_d = 1'b1;
          if (!found_q) begin
            // First match of the search: lowest matching lane wins.
            for (int i = 0; i < LANES; i++) begin
              if (first_oh_s[i]) begin
                plaintext_d  = shadow_word_q[i];
                plain_len_d  = shadow_len_q[i];
                match_lane_d = 4'(i);
              end else begin
                plaintext_d = plaintext_d;
              end
            end
          end else begin
            plaintext_d = plaintext_q;
          end
        end else begin
          found_d = found_q;
        end

        // Dispatch: legal words go to the lowest free lane, illegal ones are
        // swallowed but still flagged, and cand_last always ends the source.
        if ((state_q == ST_RUN) && hs_s) begin
          if (legal_len_s) begin
            for (int i = 0; i < LANES; i++) begin
              if (pick_oh_s[i]) begin
                inflight_d[i]             = 1'b1;
                msg_valid_d[i]            = 1'b1;
                lane_word_d[i*128 +: 128] = cand_word_i;
                lane_width_d[i*8 +: 8]    = cand_len_i;
                shadow_word_d[i]          = cand_word_i;
                shadow_len_d[i]           = cand_len_i;
              end else begin
                msg_valid_d[i] = 1'b0;
              end
            end
          end else begin
            len_error_d = 1'b1;
          end
          if (cand_last_i) begin
            src_end_d  = 1'b1;
            go_drain_s = 1'b1;
          end else begin
            src_end_d = src_end_q;
          end
        end else begin
          src_end_d = src_end_q;
        end

        if (STOP_ON_MATCH && (match_vec_s != '0)) begin
          go_drain_s = 1'b1;
        end else begin
          go_drain_s = go_drain_s;
        end

        if (state_q == ST_RUN) begin
          if (go_drain_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          // Leave DRAIN once nothing is in flight, counting this cycle's
          // completions.
          if (inflight_d == '0) begin
            state_d     = ST_DONE;
            exhausted_d = src_end_q && (!STOP_ON_MATCH || !found_d);
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q       <= ST_IDLE;
      inflight_q    <= '0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      len_error_q   <= 1'b0;
      src_end_q     <= 1'b0;
      target_q      <= 128'd0;
      plaintext_q   <= 128'd0;
      plain_len_q   <= 8'd0;
      match_lane_q  <= 4'd0;
      hashes_done_q <= {CNT_W{1'b0}};
      match_count_q <= {CNT_W{1'b0}};
      msg_valid_q   <= '0;
      lane_word_q   <= '0;
      lane_width_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        shadow_word_q[i] <= 128'd0;
        shadow_len_q[i]  <= 8'd0;
      end
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      len_error_q   <= len_error_d;
      src_end_q     <= src_end_d;
      target_q      <= target_d;
      plaintext_q   <= plaintext_d;
      plain_len_q   <= plain_len_d;
      match_lane_q  <= match_lane_d;
      hashes_done_q <= hashes_done_d;
      match_count_q <= match_count_d;
      msg_valid_q   <= msg_valid_d;
      lane_word_q   <= lane_word_d;
      lane_width_q  <= lane_width_d;
      for (int i = 0; i < LANES; i++) begin
        shadow_word_q[i] <= shadow_word_d[i];
        shadow_len_q[i]  <= shadow_len_d[i];
      end
    end
  end

  assign lane_msg_valid_o = msg_valid_q;
  assign lane_word_o      = lane_word_q;
  assign lane_width_o     = lane_width_q;
  assign busy_o           = busy_q;
  assign found_o          = found_q;
  assign exhausted_o      = exhausted_q;
  assign len_error_o      = len_error_q;
  assign plaintext_o      = plaintext_q;
  assign plain_len_o      = plain_len_q;
  assign match_lane_o     = match_lane_q;
  assign hashes_done_o    = hashes_done_q;
  assign match_count_o    = match_count_q;

endmodule

// File: tb/tb_md5_lane_scheduler.sv
// Bench for md5_lane_scheduler: instance 0 stops on first match, instance 1
// counts all matches. A hasher emulator answers each dispatched message after
// a per-lane latency; an abstract per-cycle model predicts every output.
module tb_md5_lane_scheduler;

  localparam logic [127:0] TGT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] WA  = 128'h616263;  // "abc"
  localparam logic [127:0] WB  = 128'h78797a;  // "xyz"

  logic clk;
  logic rst_n;

  logic         start   [2];
  logic [127:0] tgt     [2];
  logic         cv      [2];
  logic         cr      [2];
  logic [127:0] cw      [2];
  logic [7:0]   cl      [2];
  logic         clast   [2];
  logic [3:0]   mv      [2];
  logic [511:0] lw      [2];
  logic [31:0]  lwd     [2];
  logic [3:0]   lrdy    [2];
  logic [3:0]   lov     [2];
  logic [511:0] lh      [2];
  logic         busy    [2];
  logic         found   [2];
  logic         exh     [2];
  logic         lerr    [2];
  logic [127:0] pt      [2];
  logic [7:0]   pl      [2];
  logic [3:0]   ml      [2];
  logic [31:0]  hd      [2];
  logic [31:0]  mc      [2];

  int n_chk  = 0;
  int n_fail = 0;

  md5_lane_scheduler #(.LANES(4), .STOP_ON_MATCH(1'b1), .CNT_W(32)) u_stop (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start[0]), .target_hash_i(tgt[0]),
    .cand_valid_i(cv[0]), .cand_ready_o(cr[0]), .cand_word_i(cw[0]), .cand_len_i(cl[0]),
    .cand_last_i(clast[0]), .lane_msg_valid_o(mv[0]), .lane_word_o(lw[0]),
    .lane_width_o(lwd[0]), .lane_ready_i(lrdy[0]), .lane_out_valid_i(lov[0]),
    .lane_hash_i(lh[0]), .busy_o(busy[0]), .found_o(found[0]), .exhausted_o(exh[0]),
    .len_error_o(lerr[0]), .plaintext_o(pt[0]), .plain_len_o(pl[0]),
    .match_lane_o(ml[0]), .hashes_done_o(hd[0]), .match_count_o(mc[0]));

  md5_lane_scheduler #(.LANES(4), .STOP_ON_MATCH(1'b0), .CNT_W(32)) u_all (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start[1]), .target_hash_i(tgt[1]),
    .cand_valid_i(cv[1]), .cand_ready_o(cr[1]), .cand_word_i(cw[1]), .cand_len_i(cl[1]),
    .cand_last_i(clast[1]), .lane_msg_valid_o(mv[1]), .lane_word_o(lw[1]),
    .lane_width_o(lwd[1]), .lane_ready_i(lrdy[1]), .lane_out_valid_i(lov[1]),
    .lane_hash_i(lh[1]), .busy_o(busy[1]), .found_o(found[1]), .exhausted_o(exh[1]),
    .len_error_o(lerr[1]), .plaintext_o(pt[1]), .plain_len_o(pl[1]),
    .match_lane_o(ml[1]), .hashes_done_o(hd[1]), .match_count_o(mc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int u, input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s (dut %0d) at %0t: got %h expected %h", nm, u, $time, act, exp);
    end
  endtask

  // ---------------- hasher emulator ----------------
  int           lat   [2][4];
  int           h_cnt [2][4];
  logic [127:0] h_w   [2][4];
  bit           spur  [2][4];

  function automatic logic [127:0] digest(input logic [127:0] w);
    if (w == WA || w == WB) return TGT;
    return ~w;
  endfunction

  initial begin
    for (int u = 0; u < 2; u++) begin
      lov[u] = 4'd0;
      lh[u]  = '0;
      for (int i = 0; i < 4; i++) begin h_cnt[u][i] = 0; h_w[u][i] = '0; end
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < 4; i++) begin
          lov[u][i] = 1'b0;
          if (!rst_n) begin
            h_cnt[u][i] = 0;
          end else begin
            if (h_cnt[u][i] > 0) begin
              h_cnt[u][i]--;
              if (h_cnt[u][i] == 0) begin
                lov[u][i] = 1'b1;
                lh[u][i*128 +: 128] = digest(h_w[u][i]);
              end
            end
            if (mv[u][i]) begin
              h_w[u][i]   = lw[u][i*128 +: 128];
              h_cnt[u][i] = lat[u][i];
            end
            if (spur[u][i]) begin
              lov[u][i] = 1'b1;
              lh[u][i*128 +: 128] = tgt[u];
              spur[u][i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // m_state: 0 idle, 1 run, 2 drain, 3 done
  int           m_state [2];
  logic [3:0]   m_infl  [2];
  logic [3:0]   m_mv    [2];
  logic         m_found [2], m_exh [2], m_lerr [2], m_srcend [2];
  logic [127:0] m_pt [2], m_tgt [2];
  logic [7:0]   m_pl [2];
  logic [3:0]   m_ml [2];
  int           m_hd [2], m_mc [2];
  logic [127:0] m_w   [2][4];
  logic [7:0]   m_len [2][4];

  task automatic model_step(input int u);
    logic [3:0] free;
    bit drain, any, legal, stop;
    int old;
    stop = (u == 0);
    if (!rst_n) begin
      m_state[u] = 0; m_infl[u] = 0; m_mv[u] = 0; m_found[u] = 0; m_exh[u] = 0;
      m_lerr[u] = 0; m_srcend[u] = 0; m_pt[u] = 0; m_tgt[u] = 0; m_pl[u] = 0;
      m_ml[u] = 0; m_hd[u] = 0; m_mc[u] = 0;
      for (int i = 0; i < 4; i++) begin m_w[u][i] = 0; m_len[u][i] = 0; end
      return;
    end
    m_mv[u] = 0;
    old = m_state[u];
    if (old == 0 || old == 3) begin
      if (start[u]) begin
        m_state[u] = 1; m_found[u] = 0; m_exh[u] = 0; m_lerr[u] = 0; m_srcend[u] = 0;
        m_pt[u] = 0; m_pl[u] = 0; m_ml[u] = 0; m_hd[u] = 0; m_mc[u] = 0;
        m_tgt[u] = tgt[u]; m_infl[u] = 0;
      end
      return;
    end
    free = ~m_infl[u] & lrdy[u];
    drain = 0; any = 0;
    for (int i = 0; i < 4; i++) begin
      if (lov[u][i] && m_infl[u][i]) begin
        m_infl[u][i] = 1'b0;
        m_hd[u]++;
        if (lh[u][i*128 +: 128] == m_tgt[u]) begin
          m_mc[u]++;
          any = 1;
          if (!m_found[u]) begin
            m_found[u] = 1; m_pt[u] = m_w[u][i]; m_pl[u] = m_len[u][i]; m_ml[u] = 4'(i);
          end
        end
      end
    end
    if (old == 1 && cv[u] && free != 0) begin
      legal = (cl[u] != 0) && (cl[u] % 8 == 0) && (cl[u] <= 128);
      if (legal) begin
        for (int i = 0; i < 4; i++) begin
          if (free[i]) begin
            m_infl[u][i] = 1'b1; m_mv[u][i] = 1'b1;
            m_w[u][i] = cw[u]; m_len[u][i] = cl[u];
            break;
          end
        end
      end else begin
        m_lerr[u] = 1;
      end
      if (clast[u]) begin m_srcend[u] = 1; drain = 1; end
    end
    if (stop && any) drain = 1;
    if (old == 1 && drain) m_state[u] = 2;
    if (old == 2 && m_infl[u] == 0) begin
      m_state[u] = 3;
      m_exh[u] = m_srcend[u] && (!stop || !m_found[u]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        chk(u, "busy", 128'(busy[u]), 128'(m_state[u] == 1 || m_state[u] == 2));
        chk(u, "cand_ready", 128'(cr[u]),
            128'(m_state[u] == 1 && ((~m_infl[u] & lrdy[u]) != 4'd0)));
        chk(u, "found", 128'(found[u]), 128'(m_found[u]));
        chk(u, "exhausted", 128'(exh[u]), 128'(m_exh[u]));
        chk(u, "len_error", 128'(lerr[u]), 128'(m_lerr[u]));
        chk(u, "plaintext", pt[u], m_pt[u]);
        chk(u, "plain_len", 128'(pl[u]), 128'(m_pl[u]));
        chk(u, "match_lane", 128'(ml[u]), 128'(m_ml[u]));
        chk(u, "hashes_done", 128'(hd[u]), 128'(m_hd[u]));
        chk(u, "match_count", 128'(mc[u]), 128'(m_mc[u]));
        chk(u, "lane_msg_valid", 128'(mv[u]), 128'(m_mv[u]));
        for (int i = 0; i < 4; i++) begin
          if (m_mv[u][i]) begin
            chk(u, "lane_word", lw[u][i*128 +: 128], m_w[u][i]);
            chk(u, "lane_width", 128'(lwd[u][i*8 +: 8]), 128'(m_len[u][i]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int u);
    @(negedge clk); start[u] = 1'b1; tgt[u] = TGT;
    @(negedge clk); start[u] = 1'b0;
  endtask

  task automatic send(input int u, input logic [127:0] w, input logic [7:0] len,
                      input bit last);
    int n = 0;
    @(negedge clk);
    cv[u] = 1'b1; cw[u] = w; cl[u] = len; clast[u] = last;
    while (!cr[u]) begin
      if (m_state[u] != 1) begin cv[u] = 1'b0; clast[u] = 1'b0; return; end
      if (n >= 300) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout (dut %0d): got no cand_ready expected handshake", u);
        cv[u] = 1'b0; clast[u] = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int u);
    @(negedge clk); cv[u] = 1'b0; clast[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int n = 0;
    @(negedge clk);
    while (busy[u] && n < 3000) begin @(negedge clk); n++; end
    chk(u, "wait_done_timeout", 128'(busy[u]), 128'd0);
  endtask

  task automatic set_lat(input int u, input int a, input int b, input int c, input int d);
    lat[u][0] = a; lat[u][1] = b; lat[u][2] = c; lat[u][3] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; tgt[u] = '0; cv[u] = 1'b0; cw[u] = '0; cl[u] = 8'd0;
      clast[u] = 1'b0; lrdy[u] = 4'hF;
      for (int i = 0; i < 4; i++) begin lat[u][i] = 3; spur[u][i] = 1'b0; end
    end
    start[0] = 1'b1;  // start during reset must be ignored
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk(0, "reset_busy", 128'(busy[0]), 128'd0);
    chk(0, "reset_hd", 128'(hd[0]), 128'd0);
    chk(1, "reset_found", 128'(found[1]), 128'd0);
    chk(1, "reset_pt", pt[1], 128'd0);

    // S1: stop-on-match, 10 candidates, match on #7
    set_lat(0, 3, 4, 5, 6);
    pulse_start(0);
    for (int k = 0; k < 10; k++)
      send(0, (k == 6) ? WA : 128'h1000 + 128'(k), (k == 6) ? 8'd24 : 8'd16, k == 9);
    idle(0);
    wait_done(0);
    chk(0, "s1_found", 128'(found[0]), 128'd1);
    chk(0, "s1_plaintext", pt[0], 128'h616263);
    chk(0, "s1_plain_len", 128'(pl[0]), 128'd24);
    chk(0, "s1_match_count", 128'(mc[0]), 128'd1);
    chk(0, "s1_exhausted", 128'(exh[0]), 128'd0);
    chk(0, "s1_hd_ge7", 128'(hd[0] >= 32'd7), 128'd1);

    // S2: count-all, 20 candidates, matches on #5 and #13
    set_lat(1, 2, 7, 3, 5);
    pulse_start(1);
    for (int k = 0; k < 20; k++)
      send(1, (k == 4) ? WA : (k == 12) ? WB : 128'h2000 + 128'(k),
           (k == 4 || k == 12) ? 8'd24 : 8'd32, k == 19);
    idle(1);
    wait_done(1);
    chk(1, "s2_match_count", 128'(mc[1]), 128'd2);
    chk(1, "s2_plaintext", pt[1], WA);
    chk(1, "s2_exhausted", 128'(exh[1]), 128'd1);
    chk(1, "s2_hashes_done", 128'(hd[1]), 128'd20);

    // S3: lanes 1 and 3 complete with matches in the same cycle
    set_lat(1, 10, 6, 10, 4);
    pulse_start(1);
    send(1, 128'h3001, 8'd16, 1'b0);
    send(1, WA, 8'd24, 1'b0);
    send(1, 128'h3003, 8'd16, 1'b0);
    send(1, WB, 8'd24, 1'b1);
    idle(1);
    wait_done(1);
    chk(1, "s3_match_lane", 128'(ml[1]), 128'd1);
    chk(1, "s3_match_count", 128'(mc[1]), 128'd2);
    chk(1, "s3_plaintext", pt[1], WA);
    chk(1, "s3_hashes_done", 128'(hd[1]), 128'd4);

    // S4: illegal lengths mid-stream and on the last word
    set_lat(1, 2, 3, 4, 5);
    pulse_start(1);
    send(1, 128'h4000, 8'd8, 1'b0);
    send(1, 128'h4001, 8'd8, 1'b0);
    send(1, 128'h4002, 8'd8, 1'b0);
    send(1, 128'h4003, 8'd12, 1'b0);
    send(1, 128'h4004, 8'd0, 1'b0);
    send(1, 128'h4005, 8'd8, 1'b0);
    send(1, 128'h4006, 8'd8, 1'b0);
    send(1, 128'h4007, 8'd136, 1'b1);
    idle(1);
    wait_done(1);
    chk(1, "s4_len_error", 128'(lerr[1]), 128'd1);
    chk(1, "s4_hashes_done", 128'(hd[1]), 128'd5);
    chk(1, "s4_exhausted", 128'(exh[1]), 128'd1);
    chk(1, "s4_found", 128'(found[1]), 128'd0);

    // S5: spurious matching digest on idle lane 2
    set_lat(0, 20, 20, 2, 2);
    pulse_start(0);
    send(0, 128'h5000, 8'd8, 1'b0);
    send(0, 128'h5001, 8'd8, 1'b0);
    idle(0);
    @(posedge clk);
    spur[0][2] = 1'b1;
    repeat (3) @(negedge clk);
    chk(0, "s5_hd_spur", 128'(hd[0]), 128'd0);
    chk(0, "s5_found_spur", 128'(found[0]), 128'd0);
    chk(0, "s5_mc_spur", 128'(mc[0]), 128'd0);
    send(0, 128'h5002, 8'd8, 1'b1);
    idle(0);
    wait_done(0);
    chk(0, "s5_hashes_done", 128'(hd[0]), 128'd3);
    chk(0, "s5_exhausted", 128'(exh[0]), 128'd1);

    // S6: reset with three lanes in flight, then a normal search
    set_lat(0, 30, 30, 30, 30);
    pulse_start(0);
    send(0, 128'h6000, 8'd8, 1'b0);
    send(0, 128'h6001, 8'd8, 1'b0);
    send(0, 128'h6002, 8'd8, 1'b0);
    idle(0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk(0, "s6_busy", 128'(busy[0]), 128'd0);
    chk(0, "s6_cand_ready", 128'(cr[0]), 128'd0);
    chk(0, "s6_msg_valid", 128'(mv[0]), 128'd0);
    chk(0, "s6_hd", 128'(hd[0]), 128'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    set_lat(0, 3, 3, 3, 3);
    pulse_start(0);
    send(0, 128'h7000, 8'd8, 1'b0);
    send(0, WA, 8'd24, 1'b1);
    idle(0);
    wait_done(0);
    chk(0, "s6_found", 128'(found[0]), 128'd1);
    chk(0, "s6_plaintext", pt[0], WA);
    chk(0, "s6_match_lane", 128'(ml[0]), 128'd1);
    chk(0, "s6_hashes_done", 128'(hd[0]), 128'd2);
    chk(0, "s6_exhausted", 128'(exh[0]), 128'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/md5_lane_scheduler.md
# md5_lane_scheduler

Parametrised successor to the single-lane MD5 crack controller. It accepts candidate plaintexts from a candidate generator over a valid/ready handshake and dispatches them round-robin-free (lowest free lane first) to LANES independent MD5 hasher instances. It collects each lane's digest, compares it against the target hash, and reports the matching plaintext. It supports stop-on-first-match and exhaustive (count-all-matches) modes, source exhaustion, and a clean drain of in-flight work before reporting done.

## Interface
- LANES, 4, number of hasher lanes (1..16)
- STOP_ON_MATCH, 1, 1: stop dispatch on first match; 0: record first match, keep going until source exhausted
- CNT_W, 32, width of hashes_done and match_count
- clock  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clock
- start  in  1  one-cycle pulse; begins a search from IDLE or DONE, ignored otherwise
- target_hash  in  128  digest to match, captured on accepted start
- cand_valid  in  1  candidate available
- cand_ready  out  1  block accepts candidate this cycle
- cand_word  in  128  plaintext, right-aligned (last char in bits [120:127])
- cand_len  in  8  length in bits; legal values 8,16,...,128
- cand_last  in  1  this candidate is the final one from the source
- lane_msg_valid  out  LANES  per-lane one-cycle message strobe
- lane_word  out  128*LANES  per-lane message, lane i at slice i
- lane_width  out  8*LANES  per-lane message width in bits
- lane_ready  in  LANES  hasher i can accept a message
- lane_out_valid  in  LANES  hasher i digest valid (one-cycle)
- lane_hash  in  128*LANES  per-lane digest
- busy  out  1  high in RUN or DRAIN
- found  out  1  sticky: at least one match this search
- exhausted  out  1  source finished and no match (STOP_ON_MATCH=1) / source finished (STOP_ON_MATCH=0)
- len_error  out  1  sticky: an illegal cand_len was dropped
- plaintext  out  128  first matching candidate word
- plain_len  out  8  its length
- match_lane  out  4  lane that produced the first match
- hashes_done  out  CNT_W  digests collected this search, saturating
- match_count  out  CNT_W  matches seen this search, saturating

## Operation
- Reset values: all outputs 0; state IDLE; all in-flight flags clear; shadow registers 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start → RUN. Clear found, exhausted, len_error, counters, plaintext, plain_len, match_lane, and capture target_hash.
- RUN: cand_ready = free lane exists (not in-flight and lane_ready high). On handshake, pick the lowest-index free lane. Set its in-flight flag, and copy cand_word/cand_len to lane_word/lane_width and to the lane's shadow register. Pulse lane_msg_valid for that lane. One dispatch per cycle maximum.
- Illegal cand_len (0, not multiple of 8, >128): still handshaken, not dispatched, set len_error. cand_last on such a word still counts.
- Accepted cand_last → DRAIN.
- Completion: lane_out_valid[i] with in-flight[i] set → clear in-flight[i], hashes_done+1, and compare lane_hash slice with target. lane_out_valid on a non-in-flight lane is ignored and not counted.
- Several lanes may complete in one cycle. All are counted and compared, and match_count adds the number of matches. If there is no prior match, the lowest-index matching lane loads plaintext/plain_len/match_lane.
- A match with STOP_ON_MATCH=1 forces DRAIN (cand_ready low from next cycle). In DRAIN, completions are counted. Further matches increment match_count but do not overwrite plaintext.
- DRAIN → DONE when no lane is in flight (including the same-cycle completion). On entry to DONE, set exhausted if the source ended and (STOP_ON_MATCH=0 or !found).
- Dispatch and completion on the same lane in the same cycle cannot occur (a lane in flight is never free).

## Timing
- Candidate handshake at edge N → lane_msg_valid[i] high for exactly the cycle after N, with lane_word/lane_width valid that cycle.
- Completion sampled at edge M → counters, found, plaintext, and state update visible after M (zero extra latency).
- cand_ready is combinational from registered state, lane_ready, and in-flight flags only (no path from cand_valid).
- start in the same cycle as reset low: reset wins.
- Reset low mid-search: next edge returns all state to reset values. Hashers share this reset; in-flight digests are dropped.
- Counters saturate at all-ones, no wrap.

## Test plan
- LANES=4, STOP=1, 10 candidates, match on #7 ("abc", len 24) → found=1, plaintext[104:127]=0x616263, plain_len=24, busy falls only after all in-flight lanes complete, hashes_done ≥7.
- LANES=4, STOP=0, 20 candidates, 2 matching, last has cand_last → match_count=2, plaintext = first match, exhausted=1, hashes_done=20.
- Lanes 1 and 3 return matching digests same cycle → match_lane=1, match_count=2.
- cand_len=12 injected mid-stream → len_error=1, not dispatched, hashes_done = legal count.
- Spurious lane_out_valid on idle lane 2 → hashes_done unchanged, no match.
- Reset low while 3 lanes are in flight → next cycle: all outputs 0, state IDLE, lane_msg_valid=0. Then start works normally.
